// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared definitions for seven-segment readback logic.
//   - SEG7_0..SEG7_9, SEG7_BLANK : active-low gfedcba patterns (bit0 = a)
//   - BCD_BLANK / BCD_INVALID    : nibble codes for blank and illegal patterns
//   - cap_state_e                : capture FSM states
package seg7_pkg;

   localparam logic [6:0] SEG7_0     = 7'b1000000;
   localparam logic [6:0] SEG7_1     = 7'b1111001;
   localparam logic [6:0] SEG7_2     = 7'b0100100;
   localparam logic [6:0] SEG7_3     = 7'b0110000;
   localparam logic [6:0] SEG7_4     = 7'b0011001;
   localparam logic [6:0] SEG7_5     = 7'b0010010;
   localparam logic [6:0] SEG7_6     = 7'b0000010;
   localparam logic [6:0] SEG7_7     = 7'b1111000;
   localparam logic [6:0] SEG7_8     = 7'b0000000;
   localparam logic [6:0] SEG7_9     = 7'b0010000;
   localparam logic [6:0] SEG7_BLANK = 7'b1111111;

   localparam logic [3:0] BCD_BLANK   = 4'hF;
   localparam logic [3:0] BCD_INVALID = 4'hE;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      HELD  = 2'd2
   } cap_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode
//   Combinational inverse of a BCD-to-seven-segment decoder.
//   Ports:
//     pattern : in  7  active-low gfedcba segment pattern
//     nibble  : out 4  recovered digit, BCD_BLANK or BCD_INVALID
//     blank   : out 1  all segments off
//     invalid : out 1  pattern is neither a digit nor blank
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] nibble,
   output logic       blank,
   output logic       invalid
);

   always_comb begin
      nibble  = BCD_INVALID;
      blank   = 1'b0;
      invalid = 1'b0;
      case (pattern)
         SEG7_0:     nibble = 4'd0;
         SEG7_1:     nibble = 4'd1;
         SEG7_2:     nibble = 4'd2;
         SEG7_3:     nibble = 4'd3;
         SEG7_4:     nibble = 4'd4;
         SEG7_5:     nibble = 4'd5;
         SEG7_6:     nibble = 4'd6;
         SEG7_7:     nibble = 4'd7;
         SEG7_8:     nibble = 4'd8;
         SEG7_9:     nibble = 4'd9;
         SEG7_BLANK: begin
            nibble = BCD_BLANK;
            blank  = 1'b1;
         end
         default: begin
            nibble  = BCD_INVALID;
            invalid = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/seg7_capture.sv
// seg7_capture
//   Captures a multiplexed active-low seven-segment bus and recovers one BCD
//   digit per scanned position. Inputs are 2-flop synchronised, each
//   (digit, pattern) sample must be stable for STABLE_CYCLES cycles before it
//   is written to a staging slot, and a full set of slots is presented as a
//   frame over a valid/ready handshake.
//
//   Handshake: FRAME_VALID rises when a frame is loaded; BCD/BLANK/INVALID
//   (and DP_OUT) are stable while FRAME_VALID is high; the frame transfers on
//   a clock edge with FRAME_VALID & FRAME_READY, and FRAME_VALID falls on that
//   edge unless a new frame completes in the same cycle. FRAME_READY alone is
//   ignored.
//
//   Ports:
//     CLOCK_50      in   system clock
//     RESET_N       in   asynchronous active-low reset
//     SEG[6:0]      in   active-low segments, gfedcba
//     DIG[N-1:0]    in   active-low digit enables
//     BCD[4N-1:0]   out  frame, BCD[4k+3:4k] = digit k
//     BLANK[N-1:0]  out  digit k was blank
//     INVALID[N-1:0]out  digit k showed an illegal pattern
//     FRAME_VALID   out  frame outputs hold a complete frame
//     FRAME_READY   in   consumer accepts the frame
//     OVERRUN       out  sticky, a completed frame was dropped
//     DP            in   active-low decimal point   (SEG7_DP_EN only)
//     DP_OUT[N-1:0] out  digit k decimal point lit   (SEG7_DP_EN only)
//     capture_state out  capture FSM state, for observation
//
//   Optional feature macro: SEG7_DP_EN (decimal point capture).
module seg7_capture
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 16
)
(
   input  logic                    CLOCK_50,
   input  logic                    RESET_N,
   input  logic [6:0]              SEG,
   input  logic [NUM_DIGITS-1:0]   DIG,
   output logic [4*NUM_DIGITS-1:0] BCD,
   output logic [NUM_DIGITS-1:0]   BLANK,
   output logic [NUM_DIGITS-1:0]   INVALID,
   output logic                    FRAME_VALID,
   input  logic                    FRAME_READY,
   output logic                    OVERRUN,
`ifdef SEG7_DP_EN
   input  logic                    DP,
   output logic [NUM_DIGITS-1:0]   DP_OUT,
`endif
   output cap_state_e              capture_state
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam int K_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   // ------------------------------------------------------------------
   // Synchronisers (idle level is all ones: segments off, no digit)
   // ------------------------------------------------------------------
   logic [6:0]            seg_s1, seg_s2;
   logic [NUM_DIGITS-1:0] dig_s1, dig_s2;

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         seg_s1 <= '1;
         seg_s2 <= '1;
         dig_s1 <= '1;
         dig_s2 <= '1;
      end else begin
         seg_s1 <= SEG;
         seg_s2 <= seg_s1;
         dig_s1 <= DIG;
         dig_s2 <= dig_s1;
      end
   end

   // ------------------------------------------------------------------
   // Qualification: exactly one digit enable low
   // ------------------------------------------------------------------
   logic [3:0]     low_cnt;
   logic [K_W-1:0] sel_k;
   logic           qualified;

   always_comb begin
      low_cnt = 4'd0;
      sel_k   = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!dig_s2[i]) begin
            low_cnt = low_cnt + 4'd1;
            sel_k   = K_W'(i);
         end
      end
      qualified = (low_cnt == 4'd1);
   end

   // ------------------------------------------------------------------
   // Tracked pattern: the (k, SEG[, DP]) the counter is timing
   // ------------------------------------------------------------------
   logic [K_W-1:0] cur_k;
   logic [6:0]     cur_seg;
   logic           same_pat;
   logic           load_pat;

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         cur_k   <= '0;
         cur_seg <= '1;
      end else if (load_pat) begin
         cur_k   <= sel_k;
         cur_seg <= seg_s2;
      end
   end

`ifdef SEG7_DP_EN
   logic dp_s1, dp_s2, cur_dp;

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         dp_s1  <= 1'b1;
         dp_s2  <= 1'b1;
         cur_dp <= 1'b1;
      end else begin
         dp_s1 <= DP;
         dp_s2 <= dp_s1;
         if (load_pat) cur_dp <= dp_s2;
      end
   end

   assign same_pat = (sel_k == cur_k) && (seg_s2 == cur_seg) && (dp_s2 == cur_dp);
`else
   assign same_pat = (sel_k == cur_k) && (seg_s2 == cur_seg);
`endif

   // ------------------------------------------------------------------
   // Capture FSM
   // ------------------------------------------------------------------
   cap_state_e       state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             write_en;

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      load_pat = 1'b0;
      write_en = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (qualified) begin
               state_n  = TRACK;
               cnt_n    = CNT_W'(1);
               load_pat = 1'b1;
            end
         end
         TRACK: begin
            if (!qualified) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (same_pat) begin
               if (cnt == CNT_LAST) begin
                  // This sample is the STABLE_CYCLES-th identical one.
                  state_n  = HELD;
                  cnt_n    = CNT_MAX;
                  write_en = 1'b1;
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end else begin
               cnt_n    = CNT_W'(1);
               load_pat = 1'b1;
            end
         end
         HELD: begin
            if (!qualified) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (!same_pat) begin
               state_n  = TRACK;
               cnt_n    = CNT_W'(1);
               load_pat = 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   assign capture_state = state;

   // ------------------------------------------------------------------
   // Decode and staging
   // ------------------------------------------------------------------
   logic [3:0] dec_nibble;
   logic       dec_blank, dec_invalid;

   seg7_pattern_decode u_decode (
      .pattern (seg_s2),
      .nibble  (dec_nibble),
      .blank   (dec_blank),
      .invalid (dec_invalid)
   );

   logic [4*NUM_DIGITS-1:0] stage_bcd;
   logic [NUM_DIGITS-1:0]   stage_blank, stage_invalid;
   logic [NUM_DIGITS-1:0]   mask, write_bit;
   logic                    mask_full, handshake;

   assign write_bit = write_en ? (NUM_DIGITS'(1) << sel_k) : '0;
   assign mask_full = &mask;
   assign handshake = FRAME_VALID & FRAME_READY;

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         stage_bcd     <= {NUM_DIGITS{BCD_BLANK}};
         stage_blank   <= '1;
         stage_invalid <= '0;
      end else begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (write_bit[i]) begin
               stage_bcd[4*i +: 4] <= dec_nibble;
               stage_blank[i]      <= dec_blank;
               stage_invalid[i]    <= dec_invalid;
            end
         end
      end
   end

   // A completed mask is always consumed (loaded or dropped) in the cycle it
   // is seen, so a write landing that same cycle starts the next frame.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         mask <= '0;
      end else begin
         mask <= (mask_full ? '0 : mask) | write_bit;
      end
   end

   // ------------------------------------------------------------------
   // Frame outputs and handshake
   // ------------------------------------------------------------------
   logic frame_load;
   assign frame_load = mask_full && (!FRAME_VALID || handshake);

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         BCD         <= {NUM_DIGITS{BCD_BLANK}};
         BLANK       <= '1;
         INVALID     <= '0;
         FRAME_VALID <= 1'b0;
         OVERRUN     <= 1'b0;
      end else begin
         if (frame_load) begin
            BCD         <= stage_bcd;
            BLANK       <= stage_blank;
            INVALID     <= stage_invalid;
            FRAME_VALID <= 1'b1;
         end else if (mask_full) begin
            // Pending frame not yet taken: drop the new one, keep outputs.
            OVERRUN <= 1'b1;
         end else if (handshake) begin
            FRAME_VALID <= 1'b0;
         end
      end
   end

`ifdef SEG7_DP_EN
   logic [NUM_DIGITS-1:0] stage_dp;

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         stage_dp <= '0;
         DP_OUT   <= '0;
      end else begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (write_bit[i]) stage_dp[i] <= ~dp_s2;
         end
         if (frame_load) DP_OUT <= stage_dp;
      end
   end
`else
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture
//   Directed bench for seg7_capture with NUM_DIGITS = 4, STABLE_CYCLES = 4.
//   Inputs change 1 time unit after the rising edge; outputs are checked on
//   the falling edge (or mid-cycle for the asynchronous reset check).
module tb_seg7_capture;
   import seg7_pkg::*;

   localparam int N = 4;

   logic           CLOCK_50;
   logic           RESET_N;
   logic [6:0]     SEG;
   logic [N-1:0]   DIG;
   logic [4*N-1:0] BCD;
   logic [N-1:0]   BLANK;
   logic [N-1:0]   INVALID;
   logic           FRAME_VALID;
   logic           FRAME_READY;
   logic           OVERRUN;
   cap_state_e     capture_state;
`ifdef SEG7_DP_EN
   logic           DP;
   logic [N-1:0]   DP_OUT;
`endif

   seg7_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(4)) dut (
      .CLOCK_50      (CLOCK_50),
      .RESET_N       (RESET_N),
      .SEG           (SEG),
      .DIG           (DIG),
      .BCD           (BCD),
      .BLANK         (BLANK),
      .INVALID       (INVALID),
      .FRAME_VALID   (FRAME_VALID),
      .FRAME_READY   (FRAME_READY),
      .OVERRUN       (OVERRUN),
`ifdef SEG7_DP_EN
      .DP            (DP),
      .DP_OUT        (DP_OUT),
`endif
      .capture_state (capture_state)
   );

   // clock / reset
   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   int checks = 0;
   int errors = 0;

   // frame monitor: records every frame transferred over the handshake
   int             frames_seen = 0;
   int             fv_cycles   = 0;
   logic [4*N-1:0] last_bcd     = '0;
   logic [N-1:0]   last_blank   = '0;
   logic [N-1:0]   last_invalid = '0;

   always @(negedge CLOCK_50) begin
      if (RESET_N && FRAME_VALID) begin
         fv_cycles = fv_cycles + 1;
         if (FRAME_READY) begin
            frames_seen  = frames_seen + 1;
            last_bcd     = BCD;
            last_blank   = BLANK;
            last_invalid = INVALID;
         end
      end
   end

   // driver tasks
   task automatic tick(input int n);
      repeat (n) @(posedge CLOCK_50);
      #1;
   endtask

   task automatic show(input int k, input logic [6:0] s, input int n);
      logic [N-1:0] d;
      d      = '1;
      d[k]   = 1'b0;
      DIG    = d;
      SEG    = s;
      tick(n);
   endtask

   task automatic idle(input int n);
      DIG = '1;
      SEG = SEG7_BLANK;
      tick(n);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   int f0;
   int v0;

   initial begin
      RESET_N     = 1'b0;
      SEG         = SEG7_BLANK;
      DIG         = '1;
      FRAME_READY = 1'b0;
`ifdef SEG7_DP_EN
      DP          = 1'b1;
`endif

      // ---- reset values
      @(negedge CLOCK_50);
      chk("rst_bcd",     32'(BCD),           32'hFFFF);
      chk("rst_blank",   32'(BLANK),         32'hF);
      chk("rst_invalid", 32'(INVALID),       32'h0);
      chk("rst_fv",      32'(FRAME_VALID),   32'h0);
      chk("rst_ovr",     32'(OVERRUN),       32'h0);
      chk("rst_state",   32'(capture_state), 32'(IDLE));
      tick(1);
      RESET_N = 1'b1;
      tick(2);

      // ---- nominal frame 0,3,6,9
      FRAME_READY = 1'b1;
      f0 = frames_seen;
      v0 = fv_cycles;
      show(0, SEG7_0, 8);
      show(1, SEG7_3, 8);
      show(2, SEG7_6, 8);
      show(3, SEG7_9, 8);
      idle(4);
      @(negedge CLOCK_50);
      chk("nom_frames",  32'(frames_seen - f0), 32'd1);
      chk("nom_pulse",   32'(fv_cycles - v0),   32'd1);
      chk("nom_bcd",     32'(last_bcd),         32'h9630);
      chk("nom_blank",   32'(last_blank),       32'h0);
      chk("nom_invalid", 32'(last_invalid),     32'h0);
      chk("nom_fv_low",  32'(FRAME_VALID),      32'h0);
      chk("nom_hold",    32'(BCD),              32'h9630);
      chk("nom_ovr",     32'(OVERRUN),          32'h0);

      // ---- glitch: digit1 scanned last, shows 2 for 3 cycles then 3
      tick(1);
      f0 = frames_seen;
      show(0, SEG7_0, 8);
      show(2, SEG7_6, 8);
      show(3, SEG7_9, 8);
      show(1, SEG7_2, 3);
      show(1, SEG7_3, 8);
      idle(4);
      @(negedge CLOCK_50);
      chk("glitch_frames", 32'(frames_seen - f0), 32'd1);
      chk("glitch_bcd",    32'(last_bcd),         32'h9630);

      // ---- codes: blank and invalid patterns
      tick(1);
      f0 = frames_seen;
      show(0, SEG7_8, 8);
      show(1, SEG7_1, 8);
      show(2, 7'b1111111, 8);
      show(3, 7'b1111110, 8);
      idle(4);
      @(negedge CLOCK_50);
      chk("code_frames",  32'(frames_seen - f0), 32'd1);
      chk("code_bcd",     32'(last_bcd),         32'hEF18);
      chk("code_blank",   32'(last_blank),       32'h4);
      chk("code_invalid", 32'(last_invalid),     32'h8);

      // ---- remaining digit codes 2,4,5,7
      tick(1);
      show(0, SEG7_2, 8);
      show(1, SEG7_4, 8);
      show(2, SEG7_5, 8);
      show(3, SEG7_7, 8);
      idle(4);
      @(negedge CLOCK_50);
      chk("code2_bcd",     32'(last_bcd),     32'h7542);
      chk("code2_blank",   32'(last_blank),   32'h0);
      chk("code2_invalid", 32'(last_invalid), 32'h0);

      // ---- backpressure: two scans with FRAME_READY low
      tick(1);
      FRAME_READY = 1'b0;
      f0 = frames_seen;
      show(0, SEG7_1, 8);
      show(1, SEG7_2, 8);
      show(2, SEG7_3, 8);
      show(3, SEG7_4, 8);
      idle(4);
      @(negedge CLOCK_50);
      chk("bp1_fv",  32'(FRAME_VALID), 32'h1);
      chk("bp1_bcd", 32'(BCD),         32'h4321);
      chk("bp1_ovr", 32'(OVERRUN),     32'h0);
      tick(1);
      show(0, SEG7_5, 8);
      show(1, SEG7_6, 8);
      show(2, SEG7_7, 8);
      show(3, SEG7_8, 8);
      idle(4);
      @(negedge CLOCK_50);
      chk("bp2_fv",    32'(FRAME_VALID), 32'h1);
      chk("bp2_bcd",   32'(BCD),         32'h4321);
      chk("bp2_blank", 32'(BLANK),       32'h0);
      chk("bp2_ovr",   32'(OVERRUN),     32'h1);
      tick(1);
      FRAME_READY = 1'b1;
      @(negedge CLOCK_50);
      chk("bp_fv_before_edge", 32'(FRAME_VALID), 32'h1);
      tick(1);
      @(negedge CLOCK_50);
      chk("bp_fv_after_edge", 32'(FRAME_VALID),      32'h0);
      chk("bp_ovr_sticky",    32'(OVERRUN),          32'h1);
      chk("bp_frames",        32'(frames_seen - f0), 32'd1);
      chk("bp_taken_bcd",     32'(last_bcd),         32'h4321);

      // ---- illegal select (two digits low) between partial and final scan
      tick(1);
      f0 = frames_seen;
      show(0, SEG7_0, 8);
      show(1, SEG7_1, 8);
      show(2, SEG7_2, 8);
      DIG = 4'b1001;
      SEG = SEG7_7;
      tick(10);
      @(negedge CLOCK_50);
      chk("ill_frames", 32'(frames_seen - f0), 32'd0);
      chk("ill_fv",     32'(FRAME_VALID),      32'h0);
      chk("ill_state",  32'(capture_state),    32'(IDLE));
      tick(1);
      show(3, SEG7_3, 8);
      idle(4);
      @(negedge CLOCK_50);
      chk("ill_after_frames", 32'(frames_seen - f0), 32'd1);
      chk("ill_after_bcd",    32'(last_bcd),         32'h3210);

      // ---- asynchronous reset mid-scan
      tick(1);
      show(0, SEG7_5, 8);
      show(1, SEG7_6, 4);
      #2;
      RESET_N = 1'b0;
      #1;
      chk("mrst_bcd",     32'(BCD),           32'hFFFF);
      chk("mrst_blank",   32'(BLANK),         32'hF);
      chk("mrst_invalid", 32'(INVALID),       32'h0);
      chk("mrst_fv",      32'(FRAME_VALID),   32'h0);
      chk("mrst_ovr",     32'(OVERRUN),       32'h0);
      chk("mrst_state",   32'(capture_state), 32'(IDLE));
      tick(2);
      RESET_N = 1'b1;
      f0 = frames_seen;
      show(1, SEG7_6, 8);
      show(2, SEG7_7, 8);
      show(3, SEG7_8, 8);
      idle(4);
      @(negedge CLOCK_50);
      chk("mrst_lost_frames", 32'(frames_seen - f0), 32'd0);
      chk("mrst_lost_fv",     32'(FRAME_VALID),      32'h0);
      tick(1);
      show(0, SEG7_9, 8);
      idle(4);
      @(negedge CLOCK_50);
      chk("mrst_new_frames", 32'(frames_seen - f0), 32'd1);
      chk("mrst_new_bcd",    32'(last_bcd),         32'h8769);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
